// File: rtl/fifo_top_out_pkg.sv
// -----------------------------------------------------------------------------
// fifo_top_out_pkg
//   Shared constants for the output-side FIFO bank of the factorial machine:
//   data/depth/count widths, the bus address of FIFO0, and the bit positions
//   inside the 6-bit status word {full, empty, wr_ack, wr_err, rd_ack, rd_err}.
//   pack_flags() assembles that status word so every producer orders the bits
//   the same way.
// -----------------------------------------------------------------------------
package fifo_top_out_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int CNT_W  = 6;   // holds 0..DEPTH inclusive
    localparam int PTR_W  = 5;   // log2(DEPTH); pointers wrap naturally
    localparam int FLAG_W = 6;

    // FIFO0 lives at BASE_ADDR, FIFO1 at BASE_ADDR+1.
    localparam logic [7:0] BASE_ADDR = 8'h20;

    localparam int FLAG_FULL  = 5;
    localparam int FLAG_EMPTY = 4;
    localparam int FLAG_WACK  = 3;
    localparam int FLAG_WERR  = 2;
    localparam int FLAG_RACK  = 1;
    localparam int FLAG_RERR  = 0;

    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic full,
        input logic empty,
        input logic wack,
        input logic werr,
        input logic rack,
        input logic rerr
    );
        logic [FLAG_W-1:0] f;
        f             = '0;
        f[FLAG_FULL]  = full;
        f[FLAG_EMPTY] = empty;
        f[FLAG_WACK]  = wack;
        f[FLAG_WERR]  = werr;
        f[FLAG_RACK]  = rack;
        f[FLAG_RERR]  = rerr;
        return f;
    endfunction

endpackage

// File: rtl/fifo_top_out_fifo_32x32.sv
// -----------------------------------------------------------------------------
// fifo_32x32
//   One 32-entry x 32-bit FIFO with registered per-operation ack/err pulses.
//
//   Ports
//     clk_i      clock, all state changes on the rising edge
//     rst_i      asynchronous active-high reset; empties the FIFO, clears flags
//     wr_en_i    push din_i this cycle (takes priority if both enables are set)
//     rd_en_i    pop the head entry this cycle
//     din_i      push data
//     rd_data_o  current head entry (valid when the FIFO is not empty)
//     rd_fire_o  1 when this cycle's pop is accepted; the parent captures
//                rd_data_o into its output register on the same edge
//     cnt_o      number of stored entries, 0..32
//     flag_o     {full, empty, wr_ack, wr_err, rd_ack, rd_err}
//
//   Ack/err bits describe only the previous cycle's operation on this FIFO and
//   fall back to 0 on any cycle without an enable. A rejected push (full) or
//   pop (empty) leaves pointers, count and memory untouched.
// -----------------------------------------------------------------------------
module fifo_32x32
    import fifo_top_out_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_fire_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [FLAG_W-1:0] flag_o
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             wack_q,   wack_d;
    logic             werr_q,   werr_d;
    logic             rack_q,   rack_d;
    logic             rerr_q,   rerr_d;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);

    // A cycle is either a push or a pop, never both.
    assign do_push = wr_en_i && !full;
    assign do_pop  = rd_en_i && !wr_en_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        wack_d   = 1'b0;
        werr_d   = 1'b0;
        rack_d   = 1'b0;
        rerr_d   = 1'b0;

        if (wr_en_i) begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                cnt_d    = cnt_q + CNT_W'(1);
                wack_d   = 1'b1;
            end else begin
                werr_d   = 1'b1;
            end
        end else if (rd_en_i) begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                cnt_d    = cnt_q - CNT_W'(1);
                rack_d   = 1'b1;
            end else begin
                rerr_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            wack_q   <= 1'b0;
            werr_q   <= 1'b0;
            rack_q   <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            wack_q   <= wack_d;
            werr_q   <= werr_d;
            rack_q   <= rack_d;
            rerr_q   <= rerr_d;
        end
    end

    // Storage carries no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign rd_fire_o = do_pop;
    assign cnt_o     = cnt_q;
    assign flag_o    = pack_flags(full, empty, wack_q, werr_q, rack_q, rerr_q);

endmodule

// File: rtl/fifo_top_out.sv
// -----------------------------------------------------------------------------
// fifo_top_out
//   Output-side FIFO bank: two fifo_32x32 instances behind a memory-mapped
//   slave port.
//
//   Ports
//     clk        clock
//     reset_n    asynchronous reset, ACTIVE HIGH despite the name (legacy)
//     sel        block select
//     wr         1 = push din, 0 = pop into dout
//     address    BASE_ADDR -> FIFO0, BASE_ADDR+1 -> FIFO1, others ignored
//     din        push data
//     dout       registered pop data; holds between pops
//     fifo_cnt   entry count of the addressed FIFO (0 when not addressed)
//     fifo_flag  {full, empty, wr_ack, wr_err, rd_ack, rd_err} of the
//                addressed FIFO (0 when not addressed)
//
//   Bus protocol: an access happens on every rising edge where sel=1 and
//   address[7:1] matches BASE_ADDR[7:1]; there is no ready/stall. The access
//   always completes in that cycle, and its outcome is reported through the
//   ack/err bits on the following cycle. Pop data appears on dout one cycle
//   after the pop.
// -----------------------------------------------------------------------------
module fifo_top_out
    import fifo_top_out_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sel,
    input  logic              wr,
    input  logic [7:0]        address,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  fifo_cnt,
    output logic [FLAG_W-1:0] fifo_flag
);

    logic              hit;
    logic              pick;
    logic [1:0]        wr_en;
    logic [1:0]        rd_en;
    logic [1:0]        rd_fire;
    logic [DATA_W-1:0] rd_data [2];
    logic [CNT_W-1:0]  cnt     [2];
    logic [FLAG_W-1:0] flag    [2];

    logic [DATA_W-1:0] dout_q, dout_d;

    // Address decode: the pair of FIFOs occupies one even-aligned slot.
    assign hit  = sel && (address[7:1] == BASE_ADDR[7:1]);
    assign pick = address[0];

    assign wr_en[0] = hit &&  wr && !pick;
    assign wr_en[1] = hit &&  wr &&  pick;
    assign rd_en[0] = hit && !wr && !pick;
    assign rd_en[1] = hit && !wr &&  pick;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        fifo_32x32 u_fifo (
            .clk_i     (clk),
            .rst_i     (reset_n),
            .wr_en_i   (wr_en[g]),
            .rd_en_i   (rd_en[g]),
            .din_i     (din),
            .rd_data_o (rd_data[g]),
            .rd_fire_o (rd_fire[g]),
            .cnt_o     (cnt[g]),
            .flag_o    (flag[g])
        );
    end

    // At most one FIFO can fire per cycle since only one is addressed.
    always_comb begin
        dout_d = dout_q;
        if (rd_fire[0]) begin
            dout_d = rd_data[0];
        end else if (rd_fire[1]) begin
            dout_d = rd_data[1];
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

    always_comb begin
        fifo_cnt  = '0;
        fifo_flag = '0;
        if (hit) begin
            fifo_cnt  = pick ? cnt[1]  : cnt[0];
            fifo_flag = pick ? flag[1] : flag[0];
        end
    end

endmodule

// File: tb/tb_fifo_top_out.sv
module tb_fifo_top_out;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel;
  logic        wr;
  logic [7:0]  address;
  logic [31:0] din;
  logic [31:0] dout;
  logic [5:0]  fifo_cnt;
  logic [5:0]  fifo_flag;

  always #5 clk = ~clk;

  fifo_top_out dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sel       (sel),
    .wr        (wr),
    .address   (address),
    .din       (din),
    .dout      (dout),
    .fifo_cnt  (fifo_cnt),
    .fifo_flag (fifo_flag)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic w, input logic [7:0] a, input logic [31:0] d);
    sel = s; wr = w; address = a; din = d;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sel;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [5:0]  exp_cnt;
    logic [5:0]  exp_flag;
    logic        chk_dout;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic s, input logic w, input logic [7:0] a,
                                  input logic [31:0] d, input logic [5:0] c,
                                  input logic [5:0] f, input logic cd, input logic [31:0] ed);
    vec_t v;
    v.sel = s; v.wr = w; v.addr = a; v.din = d;
    v.exp_cnt = c; v.exp_flag = f; v.chk_dout = cd; v.exp_dout = ed;
    vecs.push_back(v);
  endfunction

  // Fill data: 1000_0000, then 0000_1111..0000_8888, 0001_1111.., 0100_1111.., 0101_1111..0101_8888
  function automatic logic [31:0] fill_val(input int i);
    logic [15:0] up;
    int k;
    if (i == 0) return 32'h1000_0000;
    k = i - 1;
    case (k / 8)
      0:       up = 16'h0000;
      1:       up = 16'h0001;
      2:       up = 16'h0100;
      default: up = 16'h0101;
    endcase
    return {up, 16'(16'h1111 * (k % 8 + 1))};
  endfunction

  // flag = {full, empty, wack, werr, rack, rerr}
  function automatic logic [5:0] fl(input logic fu, input logic em, input logic wa,
                                    input logic we, input logic ra, input logic re);
    return {fu, em, wa, we, ra, re};
  endfunction

  function automatic void build_table();
    int c;
    // Fill FIFO1 with 33 pushes; the last one overflows.
    for (int k = 0; k < 33; k++) begin
      c = (k + 1 > 32) ? 32 : k + 1;
      add_vec(1, 1, 8'h21, fill_val(k), 6'(c), fl(c == 32, 0, k < 32, k == 32, 0, 0), 0, 0);
    end
    // Pop empty FIFO0 five times; dout stays at its reset value.
    for (int k = 0; k < 5; k++)
      add_vec(1, 0, 8'h20, 32'hdead_beef, 6'd0, fl(0, 1, 0, 0, 0, 1), 1, 32'h0);
    // Independence of the two FIFOs.
    add_vec(1, 1, 8'h20, 32'h1111_1111, 6'd1,  fl(0, 0, 1, 0, 0, 0), 1, 32'h0);
    add_vec(1, 1, 8'h21, 32'h2222_2222, 6'd32, fl(1, 0, 0, 1, 0, 0), 1, 32'h0);
    // Drain FIFO0.
    add_vec(1, 0, 8'h20, 32'h0, 6'd0, fl(0, 1, 0, 0, 1, 0), 1, 32'h1111_1111);
    add_vec(1, 0, 8'h20, 32'h0, 6'd0, fl(0, 1, 0, 0, 0, 1), 1, 32'h1111_1111);
    // Drain FIFO1 with 35 pops: 32 in order, then underflow.
    for (int j = 0; j < 35; j++) begin
      if (j < 32)
        add_vec(1, 0, 8'h21, 32'h0, 6'(31 - j), fl(0, j == 31, 0, 0, 1, 0), 1, fill_val(j));
      else
        add_vec(1, 0, 8'h21, 32'h0, 6'd0, fl(0, 1, 0, 0, 0, 1), 1, fill_val(31));
    end
  endfunction

  // ---------------- reference model (scoreboard) ----------------
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] m_dout;
  logic        m_wack[2], m_werr[2], m_rack[2], m_rerr[2];

  function automatic void model_reset();
    exp_q0.delete();
    exp_q1.delete();
    m_dout = 0;
    for (int f = 0; f < 2; f++) begin
      m_wack[f] = 0; m_werr[f] = 0; m_rack[f] = 0; m_rerr[f] = 0;
    end
  endfunction

  function automatic int m_size(input int f);
    return (f == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic void model_op(input logic s, input logic w, input logic [7:0] a,
                                   input logic [31:0] d);
    int f;
    logic hit;
    hit = s && (a == 8'h20 || a == 8'h21);
    f = int'(a[0]);
    for (int i = 0; i < 2; i++) begin
      m_wack[i] = 0; m_werr[i] = 0; m_rack[i] = 0; m_rerr[i] = 0;
    end
    if (!hit) return;
    if (w) begin
      if (m_size(f) < 32) begin
        if (f == 0) exp_q0.push_back(d); else exp_q1.push_back(d);
        m_wack[f] = 1;
      end else m_werr[f] = 1;
    end else begin
      if (m_size(f) > 0) begin
        m_dout = (f == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        m_rack[f] = 1;
      end else m_rerr[f] = 1;
    end
  endfunction

  task automatic model_compare(input logic s, input logic [7:0] a);
    int f;
    logic [5:0] ec, ef;
    f = int'(a[0]);
    ec = 0; ef = 0;
    if (s && (a == 8'h20 || a == 8'h21)) begin
      ec = 6'(m_size(f));
      ef = fl(m_size(f) == 32, m_size(f) == 0, m_wack[f], m_werr[f], m_rack[f], m_rerr[f]);
    end
    check("rand_dout", dout, m_dout);
    check("rand_cnt", 32'(fifo_cnt), 32'(ec));
    check("rand_flag", 32'(fifo_flag), 32'(ef));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] w3 [3];
    int r;
    logic s, w;
    logic [7:0] a;
    logic [31:0] d;

    drive(0, 0, 8'h00, 0);
    reset_n = 1'b1;
    #12;
    // Reset state, idle readback of FIFO1 while still in reset.
    drive(1, 0, 8'h21, 0);
    #1;
    check("reset_dout", dout, 32'h0);
    check("reset_cnt", 32'(fifo_cnt), 32'd0);
    check("reset_flag", 32'(fifo_flag), 32'(fl(0, 1, 0, 0, 0, 0)));
    drive(0, 0, 8'h00, 0);
    step();
    reset_n = 1'b0;
    check("deselect_cnt", 32'(fifo_cnt), 32'd0);
    check("deselect_flag", 32'(fifo_flag), 32'd0);

    // Table-driven directed vectors.
    build_table();
    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].din);
      step();
      check($sformatf("vec%0d_cnt", i), 32'(fifo_cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_flag", i), 32'(fifo_flag), 32'(vecs[i].exp_flag));
      if (vecs[i].chk_dout) check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
    end

    // Out-of-range address: no access, outputs zero, FIFO1 untouched.
    drive(1, 1, 8'h22, 32'hffff_ffff);
    step();
    check("oor_cnt", 32'(fifo_cnt), 32'd0);
    check("oor_flag", 32'(fifo_flag), 32'd0);
    drive(0, 0, 8'h21, 0);
    step();
    drive(1, 0, 8'h21, 0);
    #1;
    check("oor_fifo1_untouched", 32'(fifo_cnt), 32'd0);

    // Wrap: push 3 and pop 3 after the pointers have gone round once.
    for (int k = 0; k < 3; k++) begin
      w3[k] = $urandom;
      drive(1, 1, 8'h21, w3[k]);
      step();
    end
    check("wrap_cnt3", 32'(fifo_cnt), 32'd3);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 8'h21, 0);
      step();
      check($sformatf("wrap_pop%0d", k), dout, w3[k]);
    end
    check("wrap_empty", 32'(fifo_flag[4]), 32'd1);

    // Async reset mid-burst: no clock edge needed.
    drive(1, 1, 8'h21, 32'h5555_aaaa);
    step();
    step();
    check("burst_cnt", 32'(fifo_cnt), 32'd2);
    #2;
    reset_n = 1'b1;
    #1;
    check("async_rst_cnt", 32'(fifo_cnt), 32'd0);
    check("async_rst_dout", dout, 32'h0);
    check("async_rst_flag", 32'(fifo_flag), 32'(fl(0, 1, 0, 0, 0, 0)));
    step();
    check("rst_hold_cnt", 32'(fifo_cnt), 32'd0);
    reset_n = 1'b0;
    model_reset();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      s = (r != 0);
      r = $urandom_range(0, 9);
      a = (r < 4) ? 8'h20 : (r < 8) ? 8'h21 : 8'($urandom_range(0, 255));
      r = $urandom_range(0, 99);
      w = ((i % 500) < 250) ? (r < 75) : (r < 30);
      d = $urandom;
      drive(s, w, a, d);
      model_op(s, w, a, d);
      step();
      model_compare(s, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
